mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 17 +
 rtl/mem_responder_cache_line_store.sv | 52 +++++
 rtl/mem_responder.sv | 151 +++++++++++++++
 tb/tb_mem_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and geometry for the direct-mapped, write-through mem_responder cache.
package mem_responder_pkg;

  localparam int LINES_DEF = 16;
  localparam int WORDS_DEF = 4;
  localparam int OFF_W_DEF = $clog2(WORDS_DEF);
  localparam int IDX_W_DEF = $clog2(LINES_DEF);
  localparam int TAG_W_DEF = 32 - IDX_W_DEF - OFF_W_DEF - 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REFILL     = 2'd1,
    RESPOND    = 2'd2,
    WRITE_THRU = 2'd3
  } state_e;

endpackage

// File: rtl/mem_responder_cache_line_store.sv
// Valid/tag/data arrays: combinational read port, synchronous word/tag write port.
module cache_line_store
  import mem_responder_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int WORDS = WORDS_DEF,
  parameter int IDX_W = $clog2(LINES),
  parameter int OFF_W = $clog2(WORDS),
  parameter int TAG_W = 32 - IDX_W - OFF_W - 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [OFF_W-1:0] rd_offset,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_word,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [OFF_W-1:0] wr_offset,
  input  logic             word_we,
  input  logic [31:0]      wr_word,
  input  logic             line_inv,
  input  logic             line_set,
  input  logic [TAG_W-1:0] wr_tag
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_word  = data_q[rd_index][rd_offset];

  always_comb begin
    valid_d = valid_q;
    if (line_inv) valid_d[wr_index] = 1'b0;
    if (line_set) valid_d[wr_index] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Tag and data contents survive reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (line_set) tag_q[wr_index] <= wr_tag;
    if (word_we)  data_q[wr_index][wr_offset] <= wr_word;
  end

endmodule

// File: rtl/mem_responder.sv
// Direct-mapped, write-through, no-write-allocate cache responder with word-by-word refill.
//   state      | meaning
//   IDLE       | serve hits, decode new miss or store
//   REFILL     | fetch WORDS beats of the missing line from backing memory
//   RESPOND    | one cycle presenting the requested word after refill
//   WRITE_THRU | forward the store to backing memory, patch the line if it hits
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        stall,
  output logic        extReq,
  output logic        extWe,
  output logic [31:0] extAddr,
  output logic [31:0] extWdata,
  input  logic [31:0] extRdata,
  input  logic        extAck
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - IDX_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

  state_e           state_q, state_d;
  logic [OFF_W-1:0] beat_q, beat_d;

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             rd_valid, line_hit, hit;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_word;
  logic             word_we, line_inv, line_set;
  logic [OFF_W-1:0] wr_offset;
  logic [31:0]      wr_word;

  assign offset   = address[OFF_W+1:2];
  assign index    = address[OFF_W+IDX_W+1:OFF_W+2];
  assign tag      = address[31:OFF_W+IDX_W+2];
  assign line_hit = rd_valid && (rd_tag == tag);
  assign hit      = memRead && line_hit;

  cache_line_store #(
    .LINES(LINES), .WORDS(WORDS), .IDX_W(IDX_W), .OFF_W(OFF_W), .TAG_W(TAG_W)
  ) u_store (
    .clk      (clk),
    .reset    (reset),
    .rd_index (index),
    .rd_offset(offset),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_word  (rd_word),
    .wr_index (index),
    .wr_offset(wr_offset),
    .word_we  (word_we),
    .wr_word  (wr_word),
    .line_inv (line_inv),
    .line_set (line_set),
    .wr_tag   (tag)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Outputs are forced quiet while reset is held so they drop the instant it asserts.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    stall     = 1'b0;
    extReq    = 1'b0;
    extWe     = 1'b0;
    extAddr   = '0;
    extWdata  = '0;
    readData  = '0;
    word_we   = 1'b0;
    wr_offset = offset;
    wr_word   = writeData;
    line_inv  = 1'b0;
    line_set  = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (memWrite) begin
            stall   = 1'b1;
            state_d = WRITE_THRU;
          end else if (memRead) begin
            if (hit) begin
              readData = rd_word;
            end else begin
              // Drop the victim line now so a partially refilled line never looks valid.
              stall    = 1'b1;
              line_inv = 1'b1;
              beat_d   = '0;
              state_d  = REFILL;
            end
          end
        end
        REFILL: begin
          stall   = 1'b1;
          extReq  = 1'b1;
          extAddr = {tag, index, beat_q, 2'b00};
          if (extAck) begin
            word_we   = 1'b1;
            wr_offset = beat_q;
            wr_word   = extRdata;
            beat_d    = beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
              line_set = 1'b1;
              state_d  = RESPOND;
            end
          end
        end
        RESPOND: begin
          readData = rd_word;
          state_d  = IDLE;
        end
        WRITE_THRU: begin
          stall    = 1'b1;
          extReq   = 1'b1;
          extWe    = 1'b1;
          extAddr  = address & ~32'h3;
          extWdata = writeData;
          if (extAck) begin
            stall   = 1'b0;
            word_we = line_hit;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder: stimulus pushes expectations, a negedge monitor checks them.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset, memRead, memWrite;
  logic [31:0] address, writeData, readData;
  logic        stall, extReq, extWe, extAck;
  logic [31:0] extAddr, extWdata, extRdata;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .address(address), .writeData(writeData), .readData(readData),
    .stall(stall), .extReq(extReq), .extWe(extWe), .extAddr(extAddr),
    .extWdata(extWdata), .extRdata(extRdata), .extAck(extAck)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } ext_t;

  ext_t        ext_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_acks  = 0;
  int          ack_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for stall to drop", name);
  endtask

  // Backing memory: acknowledges every second cycle of a held request.
  always @(posedge clk) begin
    #1;
    if (reset || !extReq) begin
      extAck  = 1'b0;
      ack_cnt = 0;
    end else begin
      ack_cnt++;
      extAck = (ack_cnt % 2 == 0);
      if (extAck) begin
        if (extWe) mem[extAddr] = extWdata;
        extRdata = mem.exists(extAddr) ? mem[extAddr] : (extAddr ^ 32'hA5A5_0000);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (memRead && !memWrite && !stall) begin
        if (rd_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_read: got %h, expected no read completion", readData);
        end else check("readData", readData, rd_q.pop_front());
      end
      if (extReq && extAck) begin
        n_acks++;
        if (ext_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_ext: got addr %h, expected no transfer", extAddr);
        end else begin
          ext_t e;
          e = ext_q.pop_front();
          check("extAddr", extAddr, e.addr);
          check("extWe", {31'd0, extWe}, {31'd0, e.we});
          if (e.we) check("extWdata", extWdata, e.wdata);
        end
      end
    end
  end

  task automatic do_read(input string name, input logic [31:0] addr, input logic [31:0] exp_data,
                         input bit exp_hit, input int exp_stalls);
    int  stalls;
    bit  done;
    rd_q.push_back(exp_data);
    if (!exp_hit)
      for (int i = 0; i < 4; i++) ext_q.push_back(ext_t'{(addr & ~32'hF) + 32'(i * 4), 1'b0, 32'h0});
    @(posedge clk); #1;
    memRead = 1'b1; memWrite = 1'b0; address = addr;
    stalls = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check({name, "_hit"}, {31'd0, !stall}, {31'd0, exp_hit});
        if (exp_hit) check({name, "_noreq"}, {31'd0, extReq}, 32'd0);
      end
      if (!stall) done = 1;
      else stalls++;
    end
    if (!done) timeout(name);
    check({name, "_stalls"}, stalls, exp_stalls);
    @(posedge clk); #1;
    memRead = 1'b0;
  endtask

  task automatic do_write(input string name, input logic [31:0] addr, input logic [31:0] data,
                          input bit also_read);
    int stalls;
    bit done;
    ext_q.push_back(ext_t'{addr, 1'b1, data});
    @(posedge clk); #1;
    memWrite = 1'b1; memRead = also_read; address = addr; writeData = data;
    stalls = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (!stall) done = 1;
      else stalls++;
    end
    if (!done) timeout(name);
    check({name, "_stalls"}, stalls, 2);
    @(posedge clk); #1;
    memWrite = 1'b0; memRead = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    address = '0; writeData = '0; extAck = 1'b0; extRdata = '0;
    mem[32'h40] = 32'h11; mem[32'h44] = 32'h22; mem[32'h48] = 32'h33; mem[32'h4C] = 32'h44;
    #2 reset = 1'b1;
    memRead = 1'b1; address = 32'h40;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_extReq", {31'd0, extReq}, 32'd0);
    check("rst_extWe", {31'd0, extWe}, 32'd0);
    check("rst_extAddr", extAddr, 32'd0);
    check("rst_extWdata", extWdata, 32'd0);
    check("rst_readData", readData, 32'd0);
    memRead = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("idle_stall", {31'd0, stall}, 32'd0);
    check("idle_extReq", {31'd0, extReq}, 32'd0);

    do_read("rd40_miss", 32'h40, 32'h11, 0, 9);
    do_read("rd48_hit", 32'h48, 32'h33, 1, 0);
    do_write("wr44", 32'h44, 32'hDEADBEEF, 0);
    do_read("rd44_hit", 32'h44, 32'hDEADBEEF, 1, 0);
    do_write("wr1000", 32'h1000, 32'h12345678, 0);
    do_read("rd1000_miss", 32'h1000, 32'h12345678, 0, 9);
    do_read("rd1004_hit", 32'h1004, 32'hA5A51004, 1, 0);
    do_read("rd440_miss", 32'h440, 32'hA5A50440, 0, 9);
    do_read("rd40_evicted", 32'h40, 32'h11, 0, 9);
    do_read("rd44_after", 32'h44, 32'hDEADBEEF, 1, 0);
    do_write("wr48_both", 32'h48, 32'hCAFEF00D, 1);
    do_read("rd48_after", 32'h48, 32'hCAFEF00D, 1, 0);

    // Abort a refill after two beats with reset.
    ext_q.push_back(ext_t'{32'h840, 1'b0, 32'h0});
    ext_q.push_back(ext_t'{32'h844, 1'b0, 32'h0});
    base = n_acks;
    @(posedge clk); #1;
    memRead = 1'b1; address = 32'h840;
    for (int c = 0; c < 100 && n_acks < base + 2; c++) @(negedge clk);
    check("abort_beats", n_acks - base, 2);
    @(posedge clk); #1;
    reset = 1'b1; memRead = 1'b0;
    #1;
    check("abort_extReq", {31'd0, extReq}, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_extAddr", extAddr, 32'd0);
    check("abort_readData", readData, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    do_read("rd40_post_rst", 32'h40, 32'h11, 0, 9);

    repeat (3) @(posedge clk);
    check("ext_q_empty", ext_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
